// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult_pkg
// Description : Shared FSM state encoding and default operand width for the
//               sequential shift-add multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
package mult_pkg;

    localparam int MULT_WIDTH = 8;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_FIN  = 2'b10;

endpackage
`default_nettype wire

// File: rtl/shift_add_multiplier_iter_counter.sv
`default_nettype none
// ============================================================================
// Module      : iter_counter
// Description : Mod-WIDTH iteration counter with enable, clear and a
//               terminal-count flag at WIDTH-1.
// Revision    : 1.0 - initial release
// ============================================================================
module iter_counter #(
    parameter int  WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic Clk,
    input  logic Reset,
    input  logic En,
    input  logic Clr,
    output logic Tc
);

    localparam logic [CNT_W-1:0] C_TC_VALUE = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] r_count;

    // WIDTH is a power of two, so the natural roll-over of r_count is the wrap.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_count <= '0;
        end else if (Clr) begin
            r_count <= '0;
        end else if (En) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign Tc = (r_count == C_TC_VALUE);

endmodule
`default_nettype wire

// File: rtl/shift_add_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : shift_add_multiplier
// Description : Sequential unsigned shift-add multiplier, one partial product
//               per clock, with Start/Busy/Done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_add_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic [WIDTH-1:0]     Multiplicand,
    input  logic [WIDTH-1:0]     Multiplier,
    output logic                 Busy,
    output logic                 Done,
    output logic [2*WIDTH-1:0]   Product
);

    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0] r_acc;      // {HI, LO}

    logic               w_accept;
    logic               w_run;
    logic               w_tc;
    logic [WIDTH:0]     w_upper;    // {C, HI} after the conditional add
    logic [2*WIDTH-1:0] w_acc_next;

    assign w_accept = (r_state == S_IDLE) && Start;
    assign w_run    = (r_state == S_RUN);

    iter_counter #(
        .WIDTH (WIDTH)
    ) u_iter_counter (
        .Clk   (Clk),
        .Reset (Reset),
        .En    (w_run),
        .Clr   (w_accept),
        .Tc    (w_tc)
    );

    // The carry out of the add lands in HI[WIDTH-1] after the shift, so no
    // separate carry flop is needed.
    always_comb begin
        w_upper = {1'b0, r_acc[2*WIDTH-1:WIDTH]};
        if (r_acc[0]) begin
            w_upper = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_mcand};
        end
        w_acc_next = {w_upper, r_acc[WIDTH-1:1]};
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state <= S_IDLE;
            r_mcand <= '0;
            r_acc   <= '0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
            Product <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    Done <= 1'b0;
                    if (Start) begin
                        r_mcand <= Multiplicand;
                        r_acc   <= {{WIDTH{1'b0}}, Multiplier};
                        Busy    <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_acc <= w_acc_next;
                    if (w_tc) begin
                        Product <= w_acc_next;
                        Busy    <= 1'b0;
                        Done    <= 1'b1;
                        r_state <= S_FIN;
                    end
                end
                S_FIN: begin
                    Done    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    Busy    <= 1'b0;
                    Done    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_shift_add_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_add_multiplier
// Description : Directed self-checking bench for shift_add_multiplier (WIDTH=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_add_multiplier;

    localparam int W = 8;

    logic            Clk = 1'b0;
    logic            Reset;
    logic            Start;
    logic [W-1:0]    Multiplicand;
    logic [W-1:0]    Multiplier;
    logic            Busy;
    logic            Done;
    logic [2*W-1:0]  Product;

    int checks   = 0;
    int failures = 0;

    shift_add_multiplier #(
        .WIDTH (W)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Start        (Start),
        .Multiplicand (Multiplicand),
        .Multiplier   (Multiplier),
        .Busy         (Busy),
        .Done         (Done),
        .Product      (Product)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Pulses Start for one edge, then waits (bounded) for Done.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         output int busy_cnt, output int lat, output logic seen_done);
        Multiplicand = a;
        Multiplier   = b;
        Start        = 1'b1;
        tick();
        Start    = 1'b0;
        busy_cnt = 0;
        lat      = 0;
        while (!Done && lat < 30) begin
            if (Busy) busy_cnt++;
            tick();
            lat++;
        end
        seen_done = Done;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        Start = 1'b0;
        Multiplicand = '0;
        Multiplier   = '0;
        tick();
        tick();
        checks++;
        if (Busy !== 1'b0 || Done !== 1'b0 || Product !== 16'h0000) begin
            failures++;
            $display("FAIL reset_state: busy=%b done=%b product=%h required 0/0/0000", Busy, Done, Product);
        end
        Reset = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int bc, lat;
        logic sd;
        do_op(8'd3, 8'd5, bc, lat, sd);
        checks++;
        if (!sd || Product !== 16'd15) begin
            failures++;
            $display("FAIL basic_3x5: done=%b product=%h required 1/000f", sd, Product);
        end
        checks++;
        if (bc != 8 || lat != 8) begin
            failures++;
            $display("FAIL basic_timing: busy_cycles=%0d latency=%0d required 8/8", bc, lat);
        end
        tick();
        checks++;
        if (Done !== 1'b0 || Busy !== 1'b0 || Product !== 16'd15) begin
            failures++;
            $display("FAIL done_one_cycle: done=%b busy=%b product=%h required 0/0/000f", Done, Busy, Product);
        end
    endtask

    task automatic test_carry();
        int bc, lat;
        logic sd;
        tick();
        do_op(8'hFF, 8'hFF, bc, lat, sd);
        checks++;
        if (!sd || Product !== 16'hFE01) begin
            failures++;
            $display("FAIL carry_ffxff: done=%b product=%h required 1/fe01", sd, Product);
        end
        tick(); tick();
        do_op(8'h80, 8'h02, bc, lat, sd);
        checks++;
        if (!sd || Product !== 16'h0100) begin
            failures++;
            $display("FAIL carry_80x02: done=%b product=%h required 1/0100", sd, Product);
        end
        tick(); tick();
    endtask

    task automatic test_zero();
        int bc, lat;
        logic sd;
        do_op(8'h00, 8'hA5, bc, lat, sd);
        checks++;
        if (!sd || Product !== 16'h0000 || bc != 8) begin
            failures++;
            $display("FAIL zero_a: done=%b product=%h busy_cycles=%0d required 1/0000/8", sd, Product, bc);
        end
        tick(); tick();
        do_op(8'hA5, 8'h00, bc, lat, sd);
        checks++;
        if (!sd || Product !== 16'h0000 || bc != 8) begin
            failures++;
            $display("FAIL zero_b: done=%b product=%h busy_cycles=%0d required 1/0000/8", sd, Product, bc);
        end
        tick(); tick();
    endtask

    task automatic test_ignore_start();
        int lat;
        logic stable_ok;
        // Previous product is 0000; seed a known value first.
        Multiplicand = 8'd7;
        Multiplier   = 8'd9;
        Start        = 1'b1;
        tick();
        Start     = 1'b0;
        lat       = 0;
        stable_ok = 1'b1;
        while (!Done && lat < 30) begin
            if (Product !== 16'h0000) stable_ok = 1'b0;
            Start = (lat == 2);
            if (lat == 2) begin
                Multiplicand = 8'hFF;
                Multiplier   = 8'hFF;
            end
            tick();
            lat++;
        end
        Start = 1'b0;
        checks++;
        if (!Done || Product !== 16'd63 || lat != 8) begin
            failures++;
            $display("FAIL ignore_start: done=%b product=%h latency=%0d required 1/003f/8", Done, Product, lat);
        end
        checks++;
        if (!stable_ok) begin
            failures++;
            $display("FAIL product_stable: product changed during run, required held at 0000");
        end
        tick(); tick();
    endtask

    task automatic test_abort();
        int bc, lat;
        logic sd;
        Multiplicand = 8'd12;
        Multiplier   = 8'd12;
        Start        = 1'b1;
        tick();
        Start = 1'b0;
        tick(); tick(); tick();
        Reset = 1'b0;
        tick();
        checks++;
        if (Busy !== 1'b0 || Done !== 1'b0 || Product !== 16'h0000) begin
            failures++;
            $display("FAIL abort: busy=%b done=%b product=%h required 0/0/0000", Busy, Done, Product);
        end
        Reset = 1'b1;
        tick();
        checks++;
        if (Done !== 1'b0 || Busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_no_done: done=%b busy=%b required 0/0", Done, Busy);
        end
        do_op(8'd2, 8'd3, bc, lat, sd);
        checks++;
        if (!sd || Product !== 16'd6 || lat != 8) begin
            failures++;
            $display("FAIL after_abort: done=%b product=%h latency=%0d required 1/0006/8", sd, Product, lat);
        end
        tick(); tick();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0]   a, b;
        logic [2*W-1:0] exp;
        int bad_prod = 0;
        int bad_time = 0;
        a = W'($urandom);
        b = W'($urandom);
        Multiplicand = a;
        Multiplier   = b;
        Start        = 1'b1;
        for (int v = 0; v < 200; v++) begin
            tick();
            checks++;
            if (Busy !== 1'b1) begin
                failures++;
                bad_time++;
                if (bad_time < 4) $display("FAIL b2b_accept[%0d]: busy=%b required 1", v, Busy);
            end
            exp = 16'(a) * 16'(b);
            Multiplicand = W'($urandom);
            Multiplier   = W'($urandom);
            for (int c = 0; c < W; c++) tick();
            checks++;
            if (Done !== 1'b1 || Product !== exp) begin
                failures++;
                bad_prod++;
                if (bad_prod < 6)
                    $display("FAIL b2b_product[%0d]: a=%h b=%h done=%b product=%h required 1/%h",
                             v, a, b, Done, Product, exp);
            end
            a = W'($urandom);
            b = W'($urandom);
            Multiplicand = a;
            Multiplier   = b;
            tick();
        end
        Start = 1'b0;
        tick(); tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_zero();
        test_ignore_start();
        test_abort();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
